// File: rtl/spi_slave_frame64_if.sv
// SPI pin and frame handshake bundle for spi_slave_frame64.
// The slave modport is the DUT view; the master modport is the view of
// whatever drives the SPI pins and consumes received frames.
interface spi_slave_frame64_if #(
    parameter int DATA_W = 64
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_load,
        output miso, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_load,
        input  miso, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_frame64.sv
// SPI mode-0 slave front end: receives DATA_W-bit frames into the clk domain
// and shifts the latched transmit word back out on miso, full duplex, MSB first.
// All SPI pins are oversampled by clk through synchronizer chains; edges are
// registered into one-cycle pulses before the frame FSM consumes them.
module spi_slave_frame64 #(
    parameter int DATA_W      = 64,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    spi_slave_frame64_if.slave bus
);
    localparam int                CNT_W     = $clog2(DATA_W) + 2;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_W + 1);
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ACTIVE = 1'b1;

    // synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q, mosi_s_q;
    logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
    logic                   sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic                   sclk_s, cs_s;

    // frame state
    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;

    // Shift each pin into its chain and detect edges on the last two synchronized samples.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_rise_s = sclk_s & ~sclk_prev_q;
        sclk_fall_s = ~sclk_s & sclk_prev_q;
        cs_rise_s   = cs_s & ~cs_prev_q;
        cs_fall_s   = ~cs_s & cs_prev_q;
    end

    // Synchronizer, history and edge-pulse registers; cs_n side resets to deselected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mosi_s_q    <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            mosi_s_q    <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_rise_s;
            sclk_fall_q <= sclk_fall_s;
            cs_rise_q   <= cs_rise_s;
            cs_fall_q   <= cs_fall_s;
        end
    end

    // Frame FSM: preload in IDLE, shift in ACTIVE, judge the bit count when cs_n rises.
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_buf_d    = bus.tx_load ? bus.tx_data : tx_buf_q;
        case (state_q)
            ST_IDLE: begin
                // a load in the same cycle as cs_fall must reach the first bit
                tx_shift_d = bus.tx_load ? bus.tx_data : tx_buf_q;
                if (cs_fall_q) begin
                    bit_cnt_d  = {CNT_W{1'b0}};
                    rx_shift_d = {DATA_W{1'b0}};
                    state_d    = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_q) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s_q};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else if (sclk_fall_q) begin
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ACTIVE);
        miso_d = tx_shift_d[DATA_W-1];
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rx_shift_q  <= {DATA_W{1'b0}};
            tx_shift_q  <= {DATA_W{1'b0}};
            tx_buf_q    <= {DATA_W{1'b0}};
            rx_data_q   <= {DATA_W{1'b0}};
            bit_cnt_q   <= {CNT_W{1'b0}};
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frame64.sv
// Self-checking bench for spi_slave_frame64: a table of directed frames,
// hand-written reset / mid-frame-load / idle-sclk sequences, and random
// frames checked against a word-level model of the slave.
`timescale 1ns/1ps
module tb_spi_slave_frame64;
    localparam int DATA_W      = 64;
    localparam int SYNC_STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_slave_frame64_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_frame64 #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0, err_cnt = 0, overlap_cnt = 0, long_cnt = 0;
    logic prev_v = 1'b0, prev_e = 1'b0;

    // model state: word the next frame will transmit, last good frame
    logic [63:0] model_txbuf;
    logic [63:0] model_rx;

    typedef struct {
        logic        do_load;
        logic [63:0] ld;
        logic [63:0] mw;
        int          n;
        logic [63:0] exp_rx;
        logic [63:0] exp_miso;
        int          exp_v;
        int          exp_e;
    } vec_t;

    // pulse monitor: counts strobes, flags overlap and strobes longer than one cycle
    always @(negedge clk) begin
        if (bus.rx_valid) valid_cnt <= valid_cnt + 1;
        if (bus.frame_err) err_cnt <= err_cnt + 1;
        if (bus.rx_valid && bus.frame_err) overlap_cnt <= overlap_cnt + 1;
        if ((bus.rx_valid && prev_v) || (bus.frame_err && prev_e)) long_cnt <= long_cnt + 1;
        prev_v <= bus.rx_valid;
        prev_e <= bus.frame_err;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // one-cycle tx_load strobe; takes exactly 20 ns from a posedge+2 alignment
    task automatic load_pulse(input logic [63:0] w);
        @(posedge clk); #2;
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        @(posedge clk); #2;
        bus.tx_load = 1'b0;
    endtask

    // mode-0 master: 100 ns sclk period, mosi changes on fall, miso sampled on rise
    task automatic spi_frame(input logic [63:0] mw, input int n, input int load_at,
                             input logic [63:0] load_word, input logic raise_cs,
                             output logic [63:0] miso_word, output int extra_ones);
        miso_word  = 64'h0;
        extra_ones = 0;
        bus.mosi   = mw[63];
        bus.cs_n   = 1'b0;
        #50;
        for (int i = 0; i < n; i++) begin
            if (i < 64) miso_word = {miso_word[62:0], bus.miso};
            else if (bus.miso) extra_ones++;
            bus.sclk = 1'b1;
            #50;
            bus.sclk = 1'b0;
            bus.mosi = (i + 1 < 64) ? mw[62 - i] : 1'b0;
            if (i == load_at) begin
                load_pulse(load_word);
                #30;
            end else begin
                #50;
            end
        end
        if (raise_cs) bus.cs_n = 1'b1;
    endtask

    // clk cycles from cs_n rise until a frame-end strobe is seen (-1 if none)
    task automatic wait_end(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (lat < 0 && (bus.rx_valid || bus.frame_err)) lat = k;
        end
        #1;
    endtask

    task automatic do_frame(input string tag, input logic do_load, input logic [63:0] ld,
                            input logic [63:0] mw, input int n, input int mid_at,
                            input logic [63:0] mid_word, input logic [63:0] exp_rx,
                            input logic [63:0] exp_miso, input int exp_v, input int exp_e);
        int v0, e0, lat, xo;
        logic [63:0] mo;
        v0 = valid_cnt;
        e0 = err_cnt;
        if (do_load) load_pulse(ld);
        spi_frame(mw, n, mid_at, mid_word, 1'b1, mo, xo);
        wait_end(lat);
        check({tag, " rx_valid_pulses"}, 64'(valid_cnt - v0), 64'(exp_v));
        check({tag, " frame_err_pulses"}, 64'(err_cnt - e0), 64'(exp_e));
        check({tag, " end_latency"}, 64'(lat), 64'(SYNC_STAGES + 2));
        check({tag, " rx_data"}, bus.rx_data, exp_rx);
        check({tag, " miso_word"}, mo, exp_miso);
        check({tag, " miso_after_last_bit"}, 64'(xo), 64'h0);
        check({tag, " busy_idle"}, 64'(bus.busy), 64'h0);
    endtask

    initial begin
        vec_t vt[5];
        int   v0, e0, xo, n;
        logic [63:0] mo, mw, ld, exp_miso;
        logic dl;

        vt[0] = '{1'b0, 64'h0, 64'hFEDCBA9876543210, 64, 64'hFEDCBA9876543210, 64'h0, 1, 0};
        vt[1] = '{1'b1, 64'h85E813540F0AB405, 64'h0, 64, 64'h0, 64'h85E813540F0AB405, 1, 0};
        vt[2] = '{1'b1, 64'h0123456789ABCDEF, 64'hAAAA5555AAAA5555, 64,
                  64'hAAAA5555AAAA5555, 64'h0123456789ABCDEF, 1, 0};
        vt[3] = '{1'b0, 64'h0, 64'h13579BDF2468ACE0, 32,
                  64'hAAAA5555AAAA5555, 64'h0000000001234567, 0, 1};
        vt[4] = '{1'b0, 64'h0, 64'h0F0F0F0F0F0F0F0F, 65,
                  64'hAAAA5555AAAA5555, 64'h0123456789ABCDEF, 0, 1};

        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = 64'h0;
        bus.tx_load = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        check("reset rx_data", bus.rx_data, 64'h0);
        check("reset rx_valid", 64'(bus.rx_valid), 64'h0);
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset frame_err", 64'(bus.frame_err), 64'h0);
        check("reset miso", 64'(bus.miso), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // directed table
        for (int i = 0; i < 5; i++) begin
            do_frame($sformatf("vec%0d", i), vt[i].do_load, vt[i].ld, vt[i].mw, vt[i].n, -1,
                     64'h0, vt[i].exp_rx, vt[i].exp_miso, vt[i].exp_v, vt[i].exp_e);
        end

        // sclk toggling with cs_n high changes nothing
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.sclk = 1'b1; #50;
            bus.sclk = 1'b0; #50;
            check("idle_sclk busy", 64'(bus.busy), 64'h0);
        end
        check("idle_sclk strobes", 64'(valid_cnt - v0 + err_cnt - e0), 64'h0);
        check("idle_sclk rx_data", bus.rx_data, 64'hAAAA5555AAAA5555);

        // load mid-frame: current frame keeps old word, next frame uses the new one
        do_frame("midload_cur", 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64, 30, 64'h1,
                 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 1, 0);
        do_frame("midload_next", 1'b0, 64'h0, 64'h3C3C3C3C3C3C3C3C, 64, -1, 64'h0,
                 64'h3C3C3C3C3C3C3C3C, 64'h1, 1, 0);

        // reset after 20 bits with cs_n held low; the tail becomes a short frame
        spi_frame(64'hDEADBEEFCAFEF00D, 20, -1, 64'h0, 1'b0, mo, xo);
        rst_n = 1'b0;
        #30;
        check("midrst rx_data", bus.rx_data, 64'h0);
        check("midrst rx_valid", 64'(bus.rx_valid), 64'h0);
        check("midrst busy", 64'(bus.busy), 64'h0);
        check("midrst frame_err", 64'(bus.frame_err), 64'h0);
        check("midrst miso", 64'(bus.miso), 64'h0);
        #20 rst_n = 1'b1;
        do_frame("midrst_tail", 1'b0, 64'h0, 64'h5A5A5A5A5A5A5A5A, 44, -1, 64'h0,
                 64'h0, 64'h0, 0, 1);
        do_frame("midrst_clean", 1'b0, 64'h0, 64'h0F1E2D3C4B5A6978, 64, -1, 64'h0,
                 64'h0F1E2D3C4B5A6978, 64'h0, 1, 0);
        model_txbuf = 64'h0;
        model_rx    = 64'h0F1E2D3C4B5A6978;

        // random frames against the word-level model
        for (int r = 0; r < 16; r++) begin
            n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 70)) : 64;
            dl = 1'($urandom_range(0, 1));
            ld = {$urandom, $urandom};
            mw = {$urandom, $urandom};
            if (dl) model_txbuf = ld;
            exp_miso = (n >= 64) ? model_txbuf : (model_txbuf >> (64 - n));
            if (n == 64) model_rx = mw;
            do_frame($sformatf("rand%0d_n%0d", r, n), dl, ld, mw, n, -1, 64'h0,
                     model_rx, exp_miso, (n == 64) ? 1 : 0, (n == 64) ? 0 : 1);
        end

        check("strobe_overlap", 64'(overlap_cnt), 64'h0);
        check("strobe_width", 64'(long_cnt), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
